// File: rtl/gunpool.sv
// gunpool: global unpooling / broadcast stage.
// Accepts one sample over valid/ready and emits it POOL_SIZE times with a
// last marker on the final copy. The holding register reloads during the
// final beat, so streams of samples are broadcast back-to-back.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   gunpool_ready_in    o  sample can be accepted this cycle
//   gunpool_valid_in    i  sample valid
//   gunpool_data_in     i  sample
//   gunpool_ready_out   i  downstream takes the beat this cycle
//   gunpool_valid_out   o  beat valid (registered)
//   gunpool_data_out    o  beat data (registered)
//   gunpool_last_out    o  final beat of a sample (registered)
module gunpool #(
  parameter int DATA_WIDTH = 12,
  parameter int POOL_SIZE  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  gunpool_ready_in,
  input  logic                  gunpool_valid_in,
  input  logic [DATA_WIDTH-1:0] gunpool_data_in,
  input  logic                  gunpool_ready_out,
  output logic                  gunpool_valid_out,
  output logic [DATA_WIDTH-1:0] gunpool_data_out,
  output logic                  gunpool_last_out
);

  localparam int CW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(POOL_SIZE - 1);

  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  logic advance;
  logic at_last;
  logic final_issue;
  logic accept;

  // Output register may load when empty or when its beat is taken.
  assign advance     = ~valid_q | gunpool_ready_out;
  assign at_last     = (count_q == LAST_CNT);
  assign final_issue = advance & hold_valid_q & at_last;

  // Refill the holding register on the same cycle its last copy leaves.
  assign gunpool_ready_in = ~hold_valid_q | final_issue;
  assign accept           = gunpool_valid_in & gunpool_ready_in;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    count_d      = count_q;
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;

    if (advance) begin
      if (hold_valid_q) begin
        valid_d = 1'b1;
        data_d  = hold_data_q;
        last_d  = at_last;
        if (at_last) begin
          count_d      = '0;
          hold_valid_d = 1'b0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end

    // A new sample overrides the end-of-broadcast clear.
    if (accept) begin
      hold_data_d  = gunpool_data_in;
      hold_valid_d = 1'b1;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
    end
  end

  assign gunpool_valid_out = valid_q;
  assign gunpool_data_out  = data_q;
  assign gunpool_last_out  = last_q;

endmodule

// File: tb/tb_gunpool.sv
// tb_gunpool: three gunpool instances (POOL_SIZE 4, 1, 3) checked against a
// queue-based stream model, plus a vector table and directed sequences.
module tb_gunpool;

  localparam int DW = 12;
  localparam int PS [3] = '{4, 1, 3};

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic          vi;
    logic [DW-1:0] di;
    logic          rin;
    logic          vo;
    logic [DW-1:0] dq;
    logic          lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic          vin  [3];
  logic [DW-1:0] din  [3];
  logic          ro   [3];
  logic          rin  [3];
  logic          vout [3];
  logic [DW-1:0] dout [3];
  logic          lout [3];

  always #5 clk = ~clk;

  gunpool #(.DATA_WIDTH(DW), .POOL_SIZE(4)) u0 (
    .clk(clk), .rst(rst),
    .gunpool_ready_in(rin[0]), .gunpool_valid_in(vin[0]),
    .gunpool_data_in(din[0]), .gunpool_ready_out(ro[0]),
    .gunpool_valid_out(vout[0]), .gunpool_data_out(dout[0]),
    .gunpool_last_out(lout[0])
  );

  gunpool #(.DATA_WIDTH(DW), .POOL_SIZE(1)) u1 (
    .clk(clk), .rst(rst),
    .gunpool_ready_in(rin[1]), .gunpool_valid_in(vin[1]),
    .gunpool_data_in(din[1]), .gunpool_ready_out(ro[1]),
    .gunpool_valid_out(vout[1]), .gunpool_data_out(dout[1]),
    .gunpool_last_out(lout[1])
  );

  gunpool #(.DATA_WIDTH(DW), .POOL_SIZE(3)) u2 (
    .clk(clk), .rst(rst),
    .gunpool_ready_in(rin[2]), .gunpool_valid_in(vin[2]),
    .gunpool_data_in(din[2]), .gunpool_ready_out(ro[2]),
    .gunpool_valid_out(vout[2]), .gunpool_data_out(dout[2]),
    .gunpool_last_out(lout[2])
  );

  // Model: beats not yet loaded into the output register, plus that register.
  beat_t         pend [3][$];
  logic          mv [3];
  logic          ml [3];
  logic [DW-1:0] md [3];
  logic          er [3];
  int            hs [3];

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl [22];

  function automatic vec_t V(logic vi, logic [DW-1:0] di, logic r,
                             logic vo, logic [DW-1:0] dq, logic lo);
    vec_t v;
    v.vi = vi; v.di = di; v.rin = r;
    v.vo = vo; v.dq = dq; v.lo = lo;
    return v;
  endfunction

  task automatic cmp(string nm, int k, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s idx %0d: got %h want %h at %0t",
               nm, k, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      er[k] = (pend[k].size() == 0) ||
              (pend[k].size() == 1 && (!mv[k] || ro[k]));
      cmp("ready_in", k, DW'(rin[k]), DW'(er[k]));
      cmp("valid_out", k, DW'(vout[k]), DW'(mv[k]));
      cmp("last_out", k, DW'(lout[k]), DW'(ml[k]));
      cmp("data_out", k, dout[k], md[k]);
      if (!rst && vout[k] && ro[k]) hs[k]++;
    end
  endtask

  task automatic tick();
    beat_t b;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pend[k].delete();
        mv[k] = 1'b0; ml[k] = 1'b0; md[k] = '0;
      end else begin
        if (!mv[k] || ro[k]) begin
          if (pend[k].size() > 0) begin
            b = pend[k].pop_front();
            mv[k] = 1'b1; md[k] = b.d; ml[k] = b.l;
          end else begin
            mv[k] = 1'b0; ml[k] = 1'b0;
          end
        end
        if (vin[k] && er[k])
          for (int i = 1; i <= PS[k]; i++) begin
            b.d = din[k];
            b.l = (i == PS[k]);
            pend[k].push_back(b);
          end
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  initial begin
    int h;
    int sent;
    logic [DW-1:0] dv;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0; din[k] = '0; ro[k] = 1'b1;
      mv[k] = 1'b0; ml[k] = 1'b0; md[k] = '0; er[k] = 1'b1; hs[k] = 0;
    end
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;

    tbl[0]  = V(1, 12'h123, 1, 0, 12'h000, 0);
    tbl[1]  = V(0, 12'h000, 0, 0, 12'h000, 0);
    tbl[2]  = V(0, 12'h000, 0, 1, 12'h123, 0);
    tbl[3]  = V(0, 12'h000, 0, 1, 12'h123, 0);
    tbl[4]  = V(0, 12'h000, 1, 1, 12'h123, 0);
    tbl[5]  = V(0, 12'h000, 1, 1, 12'h123, 1);
    tbl[6]  = V(0, 12'h000, 1, 0, 12'h123, 0);
    tbl[7]  = V(1, 12'h001, 1, 0, 12'h123, 0);
    tbl[8]  = V(1, 12'h7FF, 0, 0, 12'h123, 0);
    tbl[9]  = V(1, 12'h7FF, 0, 1, 12'h001, 0);
    tbl[10] = V(1, 12'h7FF, 0, 1, 12'h001, 0);
    tbl[11] = V(1, 12'h7FF, 1, 1, 12'h001, 0);
    tbl[12] = V(1, 12'h800, 0, 1, 12'h001, 1);
    tbl[13] = V(1, 12'h800, 0, 1, 12'h7FF, 0);
    tbl[14] = V(1, 12'h800, 0, 1, 12'h7FF, 0);
    tbl[15] = V(1, 12'h800, 1, 1, 12'h7FF, 0);
    tbl[16] = V(0, 12'h000, 0, 1, 12'h7FF, 1);
    tbl[17] = V(0, 12'h000, 0, 1, 12'h800, 0);
    tbl[18] = V(0, 12'h000, 0, 1, 12'h800, 0);
    tbl[19] = V(0, 12'h000, 1, 1, 12'h800, 0);
    tbl[20] = V(0, 12'h000, 1, 1, 12'h800, 1);
    tbl[21] = V(0, 12'h000, 1, 0, 12'h800, 0);

    for (int i = 0; i < 22; i++) begin
      vin[0] = tbl[i].vi; din[0] = tbl[i].di; ro[0] = 1'b1;
      settle();
      cmp("tbl_ready_in", i, DW'(rin[0]), DW'(tbl[i].rin));
      cmp("tbl_valid", i, DW'(vout[0]), DW'(tbl[i].vo));
      cmp("tbl_data", i, dout[0], tbl[i].dq);
      cmp("tbl_last", i, DW'(lout[0]), DW'(tbl[i].lo));
      tick();
    end

    // Random backpressure with two samples.
    h = hs[0];
    sent = 0;
    for (int c = 0; c < 200; c++) begin
      vin[0] = (sent < 2);
      din[0] = (sent == 0) ? 12'hA5A : 12'h5A5;
      ro[0] = 1'($urandom_range(0, 1));
      settle();
      if (vin[0] && er[0]) sent++;
      tick();
      if (sent == 2 && hs[0] - h == 8) break;
    end
    vin[0] = 1'b0; ro[0] = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    cmp("stall_beats", 0, DW'(hs[0] - h), DW'(8));

    // Reset in the middle of a broadcast.
    vin[0] = 1'b1; din[0] = 12'h3C3;
    cyc();
    vin[0] = 1'b0;
    h = hs[0];
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (hs[0] - h == 2) break;
    end
    cmp("pre_rst_beats", 0, DW'(hs[0] - h), DW'(2));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    cmp("rst_valid", 0, DW'(vout[0]), DW'(0));
    cmp("rst_data", 0, dout[0], DW'(0));
    cmp("rst_ready_in", 0, DW'(rin[0]), DW'(1));
    tick();
    vin[0] = 1'b1; din[0] = 12'h0F0;
    cyc();
    vin[0] = 1'b0;
    h = hs[0];
    for (int c = 0; c < 8; c++) cyc();
    cmp("post_rst_beats", 0, DW'(hs[0] - h), DW'(4));

    // POOL_SIZE=1 at full rate.
    h = hs[1];
    vin[1] = 1'b1; ro[1] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      dv = DW'(i * 16);
      din[1] = dv;
      settle();
      cmp("p1_ready_in", i, DW'(rin[1]), DW'(1));
      tick();
    end
    vin[1] = 1'b0;
    for (int c = 0; c < 3; c++) cyc();
    cmp("p1_beats", 1, DW'(hs[1] - h), DW'(3));

    // POOL_SIZE=3 single sample.
    h = hs[2];
    vin[2] = 1'b1; din[2] = 12'hFFF; ro[2] = 1'b1;
    cyc();
    vin[2] = 1'b0;
    for (int c = 0; c < 6; c++) cyc();
    cmp("p3_beats", 2, DW'(hs[2] - h), DW'(3));

    // Random traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        vin[k] = 1'($urandom_range(0, 1));
        din[k] = DW'($urandom);
        ro[k] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0; ro[k] = 1'b1;
    end
    for (int c = 0; c < 10; c++) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
